// File: rtl/pa_sched_ctrl_if.sv
// pa_sched_ctrl_if: request/response bundle between the two burst requesters
// (message-pass, page-align) and the burst scheduler.
// The layer fields carry one extra bit beyond the table depth so an
// out-of-range layer is representable and can be flagged by the scheduler.
interface pa_sched_ctrl_if #(
   parameter int LAYER_NUM = 4
);
   localparam int LW = $clog2(LAYER_NUM + 1);

   logic          mp_req_valid_i;
   logic          mp_req_ready_o;
   logic [LW-1:0] mp_req_layer_i;
   logic          pa_req_valid_i;
   logic          pa_req_ready_o;
   logic [LW-1:0] pa_req_layer_i;
   logic          mp_done_o;
   logic          pa_done_o;
   logic          req_err_o;

   modport master (
      output mp_req_valid_i, mp_req_layer_i, pa_req_valid_i, pa_req_layer_i,
      input  mp_req_ready_o, pa_req_ready_o, mp_done_o, pa_done_o, req_err_o
   );

   modport slave (
      input  mp_req_valid_i, mp_req_layer_i, pa_req_valid_i, pa_req_layer_i,
      output mp_req_ready_o, pa_req_ready_o, mp_done_o, pa_done_o, req_err_o
   );
endinterface

// File: rtl/pa_sched_ctrl.sv
// pa_sched_ctrl: burst scheduler for the page-alignment permutation datapath.
// Arbitrates message-pass vs page-align requests, replays one layer's
// {L1 shift, L2 load} table row into the datapath one beat per cycle, then
// waits out the datapath latency and pulses done to the owner.
// Optional build macro: PA_SCHED_FIXED_PRIO_EN -> message-pass always wins a
// tie and no last-served state is kept (default: round-robin).
module pa_sched_ctrl #(
   parameter int SHIFT_LENGTH = 5,
   parameter int LAYER_NUM    = 4,
   parameter int BEATS        = 3,
   parameter int DP_LATENCY   = 2
) (
   input  logic                                sys_clk,
   input  logic                                rst,
   pa_sched_ctrl_if.slave                      req_if,
   input  logic                                cfg_we_i,
   input  logic [$clog2(LAYER_NUM*BEATS)-1:0]  cfg_addr_i,
   input  logic [$clog2(SHIFT_LENGTH)-1:0]     cfg_shift_i,
   input  logic [SHIFT_LENGTH-1:0]             cfg_load_i,
   output logic                                cfg_err_o,
   output logic [$clog2(SHIFT_LENGTH)-1:0]     L1_paShift_factor_o,
   output logic [SHIFT_LENGTH-1:0]             L2_paLoad_factor_o,
   output logic                                isMsgPass_o,
   output logic                                beat_valid_o,
   output logic                                out_valid_o,
   output logic                                busy_o
);
   localparam int SW      = $clog2(SHIFT_LENGTH);
   localparam int LW      = $clog2(LAYER_NUM + 1);
   localparam int AW      = $clog2(LAYER_NUM * BEATS);
   localparam int ENTRIES = LAYER_NUM * BEATS;
   localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DW      = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

   localparam logic OWN_MP = 1'b1;
   localparam logic OWN_PA = 1'b0;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   typedef struct packed {
      logic [SW-1:0]           shift;
      logic [SHIFT_LENGTH-1:0] load;
   } entry_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DW-1:0]           dcnt_q, dcnt_d;
   logic                    owner_q, owner_d;
   logic [LW-1:0]           layer_q, layer_d;
   logic                    req_err_q, req_err_d;
   logic                    cfg_err_q, cfg_err_d;
   logic                    cfg_ok;
   entry_t                  table_q [ENTRIES];
   entry_t                  table_d [ENTRIES];
   entry_t                  ent;
   int                      idx;
   logic [SW-1:0]           shift_q, shift_d;
   logic [SHIFT_LENGTH-1:0] load_q, load_d;
   logic                    bv_q, bv_d;
   logic                    ismp_q, ismp_d;
   logic [DP_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
   logic                    idle_ok, mp_rdy, pa_rdy, drain_end;

   // Ready is suppressed while reset is held so no grant can be seen then.
   assign idle_ok   = (state_q == S_IDLE) && !rst;
   assign drain_end = (state_q == S_DRAIN) && (dcnt_q == DW'(DP_LATENCY - 1));

`ifdef PA_SCHED_FIXED_PRIO_EN
   // Fixed priority arbitration: message-pass beats page-align on a tie.
   always_comb begin
      mp_rdy = idle_ok && req_if.mp_req_valid_i;
      pa_rdy = idle_ok && req_if.pa_req_valid_i && !req_if.mp_req_valid_i;
   end
`else
   logic last_q, last_d;

   // Round-robin arbitration: on a tie the requester not served last wins.
   always_comb begin
      mp_rdy = idle_ok && req_if.mp_req_valid_i &&
               (!req_if.pa_req_valid_i || (last_q == OWN_PA));
      pa_rdy = idle_ok && req_if.pa_req_valid_i &&
               (!req_if.mp_req_valid_i || (last_q == OWN_MP));
   end

   // Last-served only moves on a completed burst, never on an error request.
   always_comb begin
      last_d = last_q;
      if (drain_end) last_d = owner_q;
   end

   // Last-served register; resets to page-align so message-pass wins first.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) last_q <= OWN_PA;
      else     last_q <= last_d;
   end
`endif

   // Burst FSM next state: grant/err in IDLE, beat count, drain count.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dcnt_d    = dcnt_q;
      owner_d   = owner_q;
      layer_d   = layer_q;
      req_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mp_rdy || pa_rdy) begin
               owner_d = mp_rdy ? OWN_MP : OWN_PA;
               layer_d = mp_rdy ? req_if.mp_req_layer_i : req_if.pa_req_layer_i;
               if (int'(layer_d) >= LAYER_NUM) begin
                  req_err_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  cnt_d   = '0;
               end
            end
         end
         S_ISSUE: begin
            if (cnt_q == CW'(BEATS - 1)) begin
               state_d = S_DRAIN;
               dcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_end) state_d = S_IDLE;
            else           dcnt_d  = dcnt_q + DW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Table write path; only IDLE writes with in-range address/shift land.
   always_comb begin
      table_d   = table_q;
      cfg_ok    = cfg_we_i && (state_q == S_IDLE) &&
                  (int'(cfg_addr_i) < ENTRIES) && (int'(cfg_shift_i) < SHIFT_LENGTH);
      cfg_err_d = cfg_we_i && !cfg_ok;
      if (cfg_ok) begin
         table_d[cfg_addr_i].shift = cfg_shift_i;
         table_d[cfg_addr_i].load  = cfg_load_i;
      end
   end

   // Next datapath controls; reading table_d lets a write landing with the
   // grant reach that burst's first beat.
   always_comb begin
      shift_d = '0;
      load_d  = '0;
      bv_d    = 1'b0;
      ismp_d  = 1'b0;
      ent     = '0;
      idx     = int'(layer_d) * BEATS + int'(cnt_d);
      if ((state_d == S_ISSUE) && (idx < ENTRIES)) ent = table_d[AW'(idx)];
      if (state_d == S_ISSUE) begin
         bv_d    = 1'b1;
         shift_d = ent.shift;
         load_d  = ent.load;
      end
      if (state_d != S_IDLE) ismp_d = owner_d;
      vld_pipe_d = DP_LATENCY'({vld_pipe_q, bv_q});
   end

   // Control/state registers.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dcnt_q     <= '0;
         owner_q    <= OWN_PA;
         layer_q    <= '0;
         req_err_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
         shift_q    <= '0;
         load_q     <= '0;
         bv_q       <= 1'b0;
         ismp_q     <= 1'b0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dcnt_q     <= dcnt_d;
         owner_q    <= owner_d;
         layer_q    <= layer_d;
         req_err_q  <= req_err_d;
         cfg_err_q  <= cfg_err_d;
         shift_q    <= shift_d;
         load_q     <= load_d;
         bv_q       <= bv_d;
         ismp_q     <= ismp_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   // Shift/load table storage; cleared by reset.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) table_q <= '{default: '0};
      else     table_q <= table_d;
   end

   assign req_if.mp_req_ready_o = mp_rdy;
   assign req_if.pa_req_ready_o = pa_rdy;
   assign req_if.mp_done_o      = drain_end && (owner_q == OWN_MP);
   assign req_if.pa_done_o      = drain_end && (owner_q == OWN_PA);
   assign req_if.req_err_o      = req_err_q;
   assign cfg_err_o             = cfg_err_q;
   assign L1_paShift_factor_o   = shift_q;
   assign L2_paLoad_factor_o    = load_q;
   assign isMsgPass_o           = ismp_q;
   assign beat_valid_o          = bv_q;
   assign out_valid_o           = vld_pipe_q[DP_LATENCY-1];
   assign busy_o                = (state_q != S_IDLE);
endmodule

// File: tb/tb_pa_sched_ctrl.sv
// tb_pa_sched_ctrl: directed checks of pa_sched_ctrl with default parameters.
module tb_pa_sched_ctrl;
   localparam int SL = 5, LN = 4, BT = 3, DL = 2;

`ifdef PA_SCHED_FIXED_PRIO_EN
   localparam logic [1:0] TIE_AFTER_MP = 2'b10;
`else
   localparam logic [1:0] TIE_AFTER_MP = 2'b01;
`endif

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic [2:0] cfg_shift;
   logic [4:0] cfg_load;
   logic       cfg_err, bv, ov, ismp, busy;
   logic [2:0] sh;
   logic [4:0] ld;

   int n_chk  = 0;
   int n_pass = 0;

   pa_sched_ctrl_if #(.LAYER_NUM(LN)) ifc ();

   pa_sched_ctrl #(.SHIFT_LENGTH(SL), .LAYER_NUM(LN), .BEATS(BT), .DP_LATENCY(DL)) dut (
      .sys_clk             (sys_clk),
      .rst                 (rst),
      .req_if              (ifc),
      .cfg_we_i            (cfg_we),
      .cfg_addr_i          (cfg_addr),
      .cfg_shift_i         (cfg_shift),
      .cfg_load_i          (cfg_load),
      .cfg_err_o           (cfg_err),
      .L1_paShift_factor_o (sh),
      .L2_paLoad_factor_o  (ld),
      .isMsgPass_o         (ismp),
      .beat_valid_o        (bv),
      .out_valid_o         (ov),
      .busy_o              (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Compare every non-handshake output at once.
   task automatic exp_o(input string tag, input logic e_busy, e_bv, e_ov, e_mp,
                        input logic [2:0] e_sh, input logic [4:0] e_ld,
                        input logic e_mpd, e_pad, e_rer, e_cer);
      chk(tag, {16'd0, busy, bv, ov, ismp, sh, ld, ifc.mp_done_o, ifc.pa_done_o,
                ifc.req_err_o, cfg_err},
               {16'd0, e_busy, e_bv, e_ov, e_mp, e_sh, e_ld, e_mpd, e_pad, e_rer, e_cer});
   endtask

   task automatic step();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic cfg_wr(input logic [3:0] a, input logic [2:0] s, input logic [4:0] l);
      cfg_we = 1'b1; cfg_addr = a; cfg_shift = s; cfg_load = l;
      step();
      cfg_we = 1'b0;
   endtask

   function automatic logic [1:0] rdy();
      return {ifc.mp_req_ready_o, ifc.pa_req_ready_o};
   endfunction

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_load = '0;
      ifc.mp_req_valid_i = 1'b1; ifc.pa_req_valid_i = 1'b1;
      ifc.mp_req_layer_i = 3'd1; ifc.pa_req_layer_i = 3'd1;
      #3;
      exp_o("rst_out", 0,0,0,0, 3'd0, 5'd0, 0,0,0,0);
      chk("rst_rdy", rdy(), 2'b00);
      ifc.mp_req_valid_i = 1'b0; ifc.pa_req_valid_i = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // Program layer 1, plus rejected writes that must not disturb it.
      cfg_wr(4'd3, 3'd1, 5'b00011); chk("cfg_ok", cfg_err, 1'b0);
      cfg_wr(4'd4, 3'd3, 5'b11100);
      cfg_wr(4'd5, 3'd4, 5'b10101); chk("cfg_ok2", cfg_err, 1'b0);
      cfg_wr(4'd3, 3'd5, 5'b11111); chk("cfg_bad_shift", cfg_err, 1'b1);
      cfg_wr(4'd12, 3'd1, 5'b11111); chk("cfg_bad_addr", cfg_err, 1'b1);
      step(); chk("cfg_err_pulse", cfg_err, 1'b0);

      // Single message-pass burst on layer 1; write during ISSUE rejected.
      ifc.mp_req_valid_i = 1'b1; ifc.mp_req_layer_i = 3'd1; #1;
      chk("b1_rdy", rdy(), 2'b10);
      step(); ifc.mp_req_valid_i = 1'b0;
      exp_o("b1_t1", 1,1,0,1, 3'd1, 5'b00011, 0,0,0,0);
      cfg_we = 1'b1; cfg_addr = 4'd4; cfg_shift = 3'd0; cfg_load = 5'd0;
      step(); cfg_we = 1'b0;
      exp_o("b1_t2", 1,1,0,1, 3'd3, 5'b11100, 0,0,0,1);
      step(); exp_o("b1_t3", 1,1,1,1, 3'd4, 5'b10101, 0,0,0,0);
      step(); exp_o("b1_t4", 1,0,1,1, 3'd0, 5'd0, 0,0,0,0);
      step(); exp_o("b1_t5", 1,0,1,1, 3'd0, 5'd0, 1,0,0,0);
      step(); exp_o("b1_t6", 0,0,0,0, 3'd0, 5'd0, 0,0,0,0);
      ifc.mp_req_valid_i = 1'b1; ifc.pa_req_valid_i = 1'b1; #1;
      chk("rr_tie", rdy(), TIE_AFTER_MP);
      ifc.mp_req_valid_i = 1'b0; ifc.pa_req_valid_i = 1'b0;

      // Out-of-range layer: error pulse, no beats, grant allowed next cycle.
      step();
      ifc.mp_req_valid_i = 1'b1; ifc.mp_req_layer_i = 3'd5; #1;
      chk("err_rdy", rdy(), 2'b10);
      step(); ifc.mp_req_valid_i = 1'b0;
      exp_o("err_t1", 0,0,0,0, 3'd0, 5'd0, 0,0,1,0);
      ifc.pa_req_valid_i = 1'b1; ifc.pa_req_layer_i = 3'd1; #1;
      chk("err_next_rdy", rdy(), 2'b01);
      step(); ifc.pa_req_valid_i = 1'b0;
      exp_o("pa_t1", 1,1,0,0, 3'd1, 5'b00011, 0,0,0,0);
      step(); step(); step();
      exp_o("pa_t4", 1,0,1,0, 3'd0, 5'd0, 0,0,0,0);
      step(); exp_o("pa_t5", 1,0,1,0, 3'd0, 5'd0, 0,1,0,0);
      step(); exp_o("pa_t6", 0,0,0,0, 3'd0, 5'd0, 0,0,0,0);

      // Write landing with the grant is seen by beat 0.
      ifc.mp_req_valid_i = 1'b1; ifc.mp_req_layer_i = 3'd1;
      cfg_we = 1'b1; cfg_addr = 4'd3; cfg_shift = 3'd2; cfg_load = 5'b01010;
      step(); ifc.mp_req_valid_i = 1'b0; cfg_we = 1'b0;
      exp_o("fwd_t1", 1,1,0,1, 3'd2, 5'b01010, 0,0,0,0);
      step(); exp_o("fwd_t2", 1,1,0,1, 3'd3, 5'b11100, 0,0,0,0);
      step(); step(); step(); step();

      // Reset during the second beat: outputs clear, no done afterwards.
      ifc.mp_req_valid_i = 1'b1; ifc.mp_req_layer_i = 3'd1;
      step(); ifc.mp_req_valid_i = 1'b0;
      step(); exp_o("mid_t2", 1,1,0,1, 3'd3, 5'b11100, 0,0,0,0);
      rst = 1'b1; ifc.mp_req_valid_i = 1'b1; ifc.pa_req_valid_i = 1'b1; #1;
      exp_o("mid_rst", 0,0,0,0, 3'd0, 5'd0, 0,0,0,0);
      chk("mid_rst_rdy", rdy(), 2'b00);
      ifc.mp_req_valid_i = 1'b0; ifc.pa_req_valid_i = 1'b0; #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); exp_o("post_rst_idle", 0,0,0,0, 3'd0, 5'd0, 0,0,0,0);
      end

      // Simultaneous requests after reset: mp first, then pa; table cleared.
      ifc.mp_req_valid_i = 1'b1; ifc.pa_req_valid_i = 1'b1;
      ifc.mp_req_layer_i = 3'd1; ifc.pa_req_layer_i = 3'd1; #1;
      chk("sim_rdy", rdy(), 2'b10);
      step(); ifc.mp_req_valid_i = 1'b0;
      exp_o("sim_t1", 1,1,0,1, 3'd0, 5'd0, 0,0,0,0);
      chk("sim_t1_rdy", rdy(), 2'b00);
      step(); step(); step(); step();
      exp_o("sim_t5", 1,0,1,1, 3'd0, 5'd0, 1,0,0,0);
      step(); chk("sim_t6_rdy", rdy(), 2'b01);
      step(); ifc.pa_req_valid_i = 1'b0;
      exp_o("sim_t7", 1,1,0,0, 3'd0, 5'd0, 0,0,0,0);
      step(); step(); step(); step();
      exp_o("sim_t11", 1,0,1,0, 3'd0, 5'd0, 0,1,0,0);
      step(); exp_o("sim_t12", 0,0,0,0, 3'd0, 5'd0, 0,0,0,0);

      // Back-to-back page-align bursts: grant every 6 cycles.
      ifc.pa_req_valid_i = 1'b1; ifc.pa_req_layer_i = 3'd2; #1;
      for (int c = 0; c < 18; c++) begin
         int ph;
         ph = c % 6;
         chk("b2b", {29'd0, ifc.pa_req_ready_o, bv, ifc.pa_done_o},
                    {29'd0, ph == 0, (ph >= 1) && (ph <= 3), ph == 5});
         step(); #1;
      end
      ifc.pa_req_valid_i = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
